// File: rtl/common_ram_fifo_ctrl.sv
// Stream FIFO controller for an external simple dual-port RAM with fixed read latency.
// Optional `level` output is enabled by defining COMMON_FIFO_CTRL_LEVEL_EN.
module common_ram_fifo_ctrl #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 9,
    parameter int RAM_LATENCY = 2    // 1 or 2 only
) (
    input  logic                  clk,
    input  logic                  rst,
    // Both stream ports use valid/ready: a word moves on a clock edge where valid
    // and ready are both high; valid must not depend on ready.
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
`ifdef COMMON_FIFO_CTRL_LEVEL_EN
    output logic [ADDR_WIDTH+1:0] level,
`endif
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram_re,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);
    localparam int OB_DEPTH = RAM_LATENCY + 2;
    localparam int OCW      = $clog2(OB_DEPTH + 1);
    localparam int SW       = OCW + 1;
    localparam logic [ADDR_WIDTH:0] RAM_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [ADDR_WIDTH-1:0]  wptr, rptr;
    logic [ADDR_WIDTH:0]    ram_cnt, ram_cnt_next;
    logic [RAM_LATENCY-1:0] inflight, inflight_next;
    logic [OCW-1:0]         ob_cnt, ob_cnt_next;
    logic [DATA_WIDTH-1:0]  ob_mem  [OB_DEPTH];
    logic [DATA_WIDTH-1:0]  ob_next [OB_DEPTH];
    logic [SW-1:0]          infl_cnt, infl_next_cnt, pending;
    logic                   wr, push, pop;

    // Reset gates the write port so a held reset never writes the RAM.
    assign wr        = s_valid & s_ready & ~rst;
    assign ram_we    = wr;
    assign ram_waddr = wptr;
    assign ram_wdata = s_data;
    assign ram_raddr = rptr;
    assign push      = inflight[RAM_LATENCY-1];
    assign m_valid   = (ob_cnt != '0);
    assign pop       = m_valid & m_ready;
    assign m_data    = ob_mem[0];

    always_comb begin
        infl_cnt      = '0;
        infl_next_cnt = '0;
        inflight_next = '0;
        inflight_next[0] = ram_re;
        for (int i = 1; i < RAM_LATENCY; i++) inflight_next[i] = inflight[i-1];
        for (int i = 0; i < RAM_LATENCY; i++) begin
            infl_cnt      = infl_cnt + SW'(inflight[i]);
            infl_next_cnt = infl_next_cnt + SW'(inflight_next[i]);
        end
    end

    // Issue only from registered state: reserving a buffer slot per in-flight read
    // guarantees the capture buffer never overflows.
    assign pending = SW'(ob_cnt) + infl_cnt;
    assign ram_re  = (ram_cnt != '0) && (pending < SW'(OB_DEPTH));

    always_comb begin
        ram_cnt_next = ram_cnt;
        case ({wr, ram_re})
            2'b10:   ram_cnt_next = ram_cnt + (ADDR_WIDTH+1)'(1);
            2'b01:   ram_cnt_next = ram_cnt - (ADDR_WIDTH+1)'(1);
            default: ram_cnt_next = ram_cnt;
        endcase
        ob_cnt_next = ob_cnt;
        if (push && !pop)      ob_cnt_next = ob_cnt + OCW'(1);
        else if (pop && !push) ob_cnt_next = ob_cnt - OCW'(1);
    end

    // Capture buffer shifts toward entry 0 on pop, so the head is always a register
    // and vacated entries fill with zero.
    always_comb begin
        for (int i = 0; i < OB_DEPTH; i++) ob_next[i] = ob_mem[i];
        if (pop) begin
            for (int i = 0; i < OB_DEPTH - 1; i++) ob_next[i] = ob_mem[i+1];
            ob_next[OB_DEPTH-1] = '0;
        end
        for (int i = 0; i < OB_DEPTH; i++) begin
            if (push && (OCW'(i) == (ob_cnt - OCW'(pop)))) ob_next[i] = ram_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            ram_cnt  <= '0;
            inflight <= '0;
            ob_cnt   <= '0;
            s_ready  <= 1'b1;
            for (int i = 0; i < OB_DEPTH; i++) ob_mem[i] <= '0;
        end else begin
            if (wr)     wptr <= wptr + ADDR_WIDTH'(1);
            if (ram_re) rptr <= rptr + ADDR_WIDTH'(1);
            ram_cnt  <= ram_cnt_next;
            inflight <= inflight_next;
            ob_cnt   <= ob_cnt_next;
            s_ready  <= (ram_cnt_next != RAM_FULL);
            for (int i = 0; i < OB_DEPTH; i++) ob_mem[i] <= ob_next[i];
        end
    end

`ifdef COMMON_FIFO_CTRL_LEVEL_EN
    always_ff @(posedge clk) begin
        if (rst) level <= '0;
        else     level <= (ADDR_WIDTH+2)'(ram_cnt_next) + (ADDR_WIDTH+2)'(infl_next_cnt)
                          + (ADDR_WIDTH+2)'(ob_cnt_next);
    end
`endif

endmodule

// File: tb/tb_common_ram_fifo_ctrl.sv
// Bench for common_ram_fifo_ctrl (ADDR_WIDTH=4, RAM_LATENCY=2) with a RAM model,
// a cycle-level occupancy model and directed literal checks.
module tb_common_ram_fifo_ctrl;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int L  = 2;
    localparam int D  = 1 << AW;
    localparam int B  = L + 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid, s_ready, m_valid, m_ready;
    logic [DW-1:0] s_data, m_data;
    logic          ram_we, ram_re;
    logic [AW-1:0] ram_waddr, ram_raddr;
    logic [DW-1:0] ram_wdata, ram_rdata;
`ifdef COMMON_FIFO_CTRL_LEVEL_EN
    logic [AW+1:0] level;
`endif

    common_ram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_LATENCY(L)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
`ifdef COMMON_FIFO_CTRL_LEVEL_EN
        .level(level),
`endif
        .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
        .ram_re(ram_re), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // RAM beside the controller: write port plus read pipeline of depth L
    logic [DW-1:0] mem [D];
    logic [DW-1:0] rd1, rd2;
    initial begin
        for (int i = 0; i < D; i++) mem[i] = '0;
        rd1 = '0;
        rd2 = '0;
    end
    always @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= ram_wdata;
        if (ram_re) rd1 <= mem[ram_raddr];
        rd2 <= rd1;
    end
    assign ram_rdata = (L == 1) ? rd1 : rd2;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    logic chk_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    // Occupancy model: words accepted, issued, landed (L+1 cycles after issue), popped
    logic [DW-1:0] exp_q [$];
    int iss_t [$];
    int n_acc = 0, n_iss = 0, n_land = 0, n_pop = 0;
    int m_ram, m_infl, m_ob;
    logic e_sready, e_mvalid, e_re, e_we, e_pop;

    always @(negedge clk) begin
        if (chk_en) begin
            while (iss_t.size() > 0 && iss_t[0] + L + 1 <= cyc) begin
                void'(iss_t.pop_front());
                n_land++;
            end
            m_ram    = n_acc - n_iss;
            m_infl   = n_iss - n_land;
            m_ob     = n_land - n_pop;
            e_sready = (m_ram != D);
            e_mvalid = (m_ob > 0);
            e_re     = (m_ram > 0) && (m_ob + m_infl < B);
            e_we     = s_valid && e_sready && !rst;
            e_pop    = e_mvalid && m_ready;
            chk("s_ready", s_ready, e_sready);
            chk("m_valid", m_valid, e_mvalid);
            chk("ram_re", ram_re, e_re);
            chk("ram_we", ram_we, e_we);
            chk("ram_waddr", ram_waddr, n_acc % D);
            chk("ram_raddr", ram_raddr, n_iss % D);
            chk("ram_wdata", ram_wdata, s_data);
            if (e_mvalid) chk("m_data", m_data, exp_q[0]);
`ifdef COMMON_FIFO_CTRL_LEVEL_EN
            chk("level", level, m_ram + m_infl + m_ob);
`endif
            if (rst) begin
                exp_q.delete();
                iss_t.delete();
                n_acc = 0; n_iss = 0; n_land = 0; n_pop = 0;
            end else begin
                if (e_we)  begin exp_q.push_back(s_data); n_acc++; end
                if (e_re)  begin iss_t.push_back(cyc); n_iss++; end
                if (e_pop) begin void'(exp_q.pop_front()); n_pop++; end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        m_ready = 1'b1;
        repeat (n) step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    int n_take;
    logic [DW-1:0] outs [$];

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        step();
        chk_en = 1'b1;
        at_neg();
        chk("rst_s_ready", s_ready, 1);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_re", ram_re, 0);
        chk("rst_waddr", ram_waddr, 0);
        chk("rst_raddr", ram_raddr, 0);
        step(); step();
        rst = 1'b0;

        // single word: accepted in cycle 0, visible in cycle 4
        s_valid = 1'b1; s_data = 8'hA5; m_ready = 1'b1;
        at_neg();
        chk("single_we", ram_we, 1);
        step();
        s_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            at_neg();
            if (k == 1) chk("single_re", ram_re, 1);
            chk("single_m_valid", m_valid, (k == 4));
            if (k == 4) chk("single_m_data", m_data, 8'hA5);
            step();
        end

        // reset held 3 clocks mid-stream
        m_ready = 1'b0; s_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            s_data = 8'h40 + 8'(k);
            step();
        end
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0; s_valid = 1'b0;
        at_neg();
        chk("rst3_m_valid", m_valid, 0);
        chk("rst3_ram_we", ram_we, 0);
        chk("rst3_ram_re", ram_re, 0);
        chk("rst3_s_ready", s_ready, 1);
`ifdef COMMON_FIFO_CTRL_LEVEL_EN
        chk("rst3_level", level, 0);
`endif
        step();
        idle(5);

        // fill with the consumer stalled: 16 in RAM + 4 in the capture buffer
        n_take = 0; m_ready = 1'b0;
        for (int k = 0; k < 25; k++) begin
            s_valid = 1'b1; s_data = 8'(k);
            at_neg();
            if (s_ready) n_take++;
            step();
        end
        s_valid = 1'b0;
        chk("fill_count", n_take, 20);
        at_neg();
        chk("fill_s_ready", s_ready, 0);
`ifdef COMMON_FIFO_CTRL_LEVEL_EN
        chk("fill_level", level, 20);
`endif
        step();

        // full release: one pop, s_ready back two cycles later
        s_valid = 1'b1; s_data = 8'h80; m_ready = 1'b1;
        at_neg();
        chk("rel_p0_s_ready", s_ready, 0);
        if (m_valid) outs.push_back(m_data);
        step();
        m_ready = 1'b0;
        at_neg();
        chk("rel_p1_s_ready", s_ready, 0);
        chk("rel_p1_ram_re", ram_re, 1);
        step();
        at_neg();
        chk("rel_p2_s_ready", s_ready, 1);
        step();
        s_valid = 1'b0; m_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            at_neg();
            if (m_valid) outs.push_back(m_data);
            step();
        end
        chk("rel_out_count", outs.size(), 21);
        for (int k = 0; k < outs.size() && k < 21; k++)
            chk("rel_out_order", outs[k], (k < 20) ? k : 8'h80);

        // streaming at one word per clock
        m_ready = 1'b1;
        for (int k = 0; k < 106; k++) begin
            s_valid = (k < 100); s_data = 8'(k);
            at_neg();
            chk("stream_m_valid", m_valid, (k >= 4 && k <= 103));
            if (k >= 4 && k <= 103) chk("stream_m_data", m_data, (k - 4) & 8'hff);
            step();
        end
        idle(5);

        // reset with 7 words held and 2 reads in flight
        m_ready = 1'b0;
        for (int k = 0; k < 9; k++) begin
            s_valid = 1'b1; s_data = 8'h10 + 8'(k);
            m_ready = (k == 8);
            step();
        end
        s_valid = 1'b0; m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0; s_valid = 1'b1; s_data = 8'h3C; m_ready = 1'b1;
        step();
        s_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            at_neg();
            chk("mid_m_valid", m_valid, (k == 4));
            if (k == 4) chk("mid_m_data", m_data, 8'h3C);
            step();
        end
        idle(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
